// File: rtl/btb_lookup_pkg.sv
// Shared constants, counter encodings and way-field positions for the
// 2-way branch target buffer.
package btb_lookup_pkg;

  localparam int BTB_SETS  = 8;
  localparam int BTB_TAG_W = 27;
  localparam int BTB_IDX_W = $clog2(BTB_SETS);
  localparam int WAY_W     = 64;
  localparam int BTB_SET_W = 2 * WAY_W;

  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'b00,
    WEAK_NOT_TAKEN   = 2'b01,
    WEAK_TAKEN       = 2'b10,
    STRONG_TAKEN     = 2'b11
  } bp_state_e;

  // Way layout: {valid, tag, target, state, 2'b00}
  localparam int WAY_VALID_BIT = 63;
  localparam int WAY_TAG_MSB   = 62;
  localparam int WAY_TAG_LSB   = 36;
  localparam int WAY_TGT_MSB   = 35;
  localparam int WAY_TGT_LSB   = 4;
  localparam int WAY_ST_MSB    = 3;
  localparam int WAY_ST_LSB    = 2;

endpackage

// File: rtl/btb_lookup_if.sv
// Lookup/update bundle between the fetch/EX pipeline (master) and the BTB (slave).
interface btb_lookup_if;
  import btb_lookup_pkg::*;

  logic [31:0]           pc_if;
  logic                  stall;
  logic                  flush;
  logic [31:0]           pc_ex;
  logic                  update_en;
  logic [BTB_SET_W-1:0]  write_set;
  logic                  next_LRU_write;
  logic                  predict_taken;
  logic [31:0]           predict_target;
  logic                  predict_taken_ex;
  logic [31:0]           predict_target_ex;
  logic [BTB_SET_W-1:0]  update_set;
  logic [BTB_TAG_W-1:0]  update_tag;
  logic [BTB_IDX_W-1:0]  update_index;
  logic [BTB_SETS-1:0]   LRU;

  modport master (
    output pc_if, stall, flush, pc_ex, update_en, write_set, next_LRU_write,
    input  predict_taken, predict_target, predict_taken_ex, predict_target_ex,
           update_set, update_tag, update_index, LRU
  );

  modport slave (
    input  pc_if, stall, flush, pc_ex, update_en, write_set, next_LRU_write,
    output predict_taken, predict_target, predict_taken_ex, predict_target_ex,
           update_set, update_tag, update_index, LRU
  );
endinterface

// File: rtl/btb_way_match.sv
// Tag compare and taken/target decode for a single BTB way.
module btb_way_match
  import btb_lookup_pkg::*;
#(
  parameter int TAG_W = BTB_TAG_W
) (
  input  logic [WAY_W-1:0] way_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             hit_o,
  output logic             taken_o,
  output logic [31:0]      target_o
);

  bp_state_e state;
  logic      unused_way_bits;

  assign state    = bp_state_e'(way_i[WAY_ST_MSB:WAY_ST_LSB]);
  assign hit_o    = way_i[WAY_VALID_BIT] && (way_i[WAY_TAG_LSB +: TAG_W] == tag_i);
  assign taken_o  = hit_o && ((state == WEAK_TAKEN) || (state == STRONG_TAKEN));
  // Target is forced to zero unless this way produces a taken prediction.
  assign target_o = taken_o ? way_i[WAY_TGT_MSB:WAY_TGT_LSB] : 32'h0;

  assign unused_way_bits = ^way_i[1:0];

endmodule

// File: rtl/btb_lookup.sv
// BTB storage, zero-latency IF prediction with write-first bypass, and the
// IF/ID -> ID/EX prediction pipeline feeding the EX-stage update logic.
module btb_lookup
  import btb_lookup_pkg::*;
#(
  parameter int NUM_SETS = BTB_SETS,
  parameter int TAG_W    = BTB_TAG_W
) (
  input  logic         clk,
  input  logic         rst,
  btb_lookup_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int SET_W = 2 * WAY_W;

  logic [SET_W-1:0]    set_q [NUM_SETS];
  logic [NUM_SETS-1:0] lru_q;

  logic [IDX_W-1:0]    idx_if;
  logic [IDX_W-1:0]    idx_ex;
  logic [TAG_W-1:0]    tag_if;
  logic [SET_W-1:0]    lookup_set;

  logic                hit_w1, taken_w1, hit_w2, taken_w2;
  logic [31:0]         target_w1, target_w2;

  logic                taken_p0;
  logic [31:0]         target_p0;
  logic                taken_p1_d, taken_p1_q, taken_p2_d, taken_p2_q;
  logic [31:0]         target_p1_d, target_p1_q, target_p2_d, target_p2_q;

  logic                unused_pc_bits;

  assign idx_if = bus.pc_if[IDX_W+1:2];
  assign idx_ex = bus.pc_ex[IDX_W+1:2];
  assign tag_if = bus.pc_if[31:32-TAG_W];

  assign unused_pc_bits = ^{bus.pc_if[1:0], bus.pc_ex[1:0]};

  // Write-first: a same-index update this cycle is what the fetch must see.
  always_comb begin
    lookup_set = set_q[idx_if];
    if (bus.update_en && !rst && (idx_ex == idx_if)) begin
      lookup_set = bus.write_set;
    end
  end

  btb_way_match #(.TAG_W(TAG_W)) u_match_w1 (
    .way_i    (lookup_set[SET_W-1 -: WAY_W]),
    .tag_i    (tag_if),
    .hit_o    (hit_w1),
    .taken_o  (taken_w1),
    .target_o (target_w1)
  );

  btb_way_match #(.TAG_W(TAG_W)) u_match_w2 (
    .way_i    (lookup_set[WAY_W-1:0]),
    .tag_i    (tag_if),
    .hit_o    (hit_w2),
    .taken_o  (taken_w2),
    .target_o (target_w2)
  );

  // ---- p0: IF-stage prediction; way1 has priority on a double hit ----
  assign taken_p0  = hit_w1 ? taken_w1  : taken_w2;
  assign target_p0 = hit_w1 ? target_w1 : target_w2;

  // ---- p1/p2: IF/ID and ID/EX prediction registers ----
  always_comb begin
    taken_p1_d  = taken_p1_q;
    target_p1_d = target_p1_q;
    taken_p2_d  = taken_p2_q;
    target_p2_d = target_p2_q;
    if (bus.flush) begin
      taken_p1_d  = 1'b0;
      target_p1_d = 32'h0;
      taken_p2_d  = 1'b0;
      target_p2_d = 32'h0;
    end else if (!bus.stall) begin
      taken_p1_d  = taken_p0;
      target_p1_d = target_p0;
      taken_p2_d  = taken_p1_q;
      target_p2_d = target_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_p1_q  <= 1'b0;
      target_p1_q <= 32'h0;
      taken_p2_q  <= 1'b0;
      target_p2_q <= 32'h0;
    end else begin
      taken_p1_q  <= taken_p1_d;
      target_p1_q <= target_p1_d;
      taken_p2_q  <= taken_p2_d;
      target_p2_q <= target_p2_d;
    end
  end

  // Storage and LRU: only the EX update path writes; lookups never touch LRU.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        set_q[i] <= '0;
      end
      lru_q <= '0;
    end else if (bus.update_en) begin
      set_q[idx_ex] <= bus.write_set;
      lru_q[idx_ex] <= bus.next_LRU_write;
    end
  end

  assign bus.predict_taken     = taken_p0;
  assign bus.predict_target    = target_p0;
  assign bus.predict_taken_ex  = taken_p2_q;
  assign bus.predict_target_ex = target_p2_q;
  assign bus.update_set        = set_q[idx_ex];
  assign bus.update_tag        = bus.pc_ex[31:32-TAG_W];
  assign bus.update_index      = idx_ex;
  assign bus.LRU               = lru_q;

endmodule

// File: doc/btb_lookup.md
Name: btb_lookup

Overview:
- IF-stage read side and storage of the 2-way, 8-set branch target buffer.
- Holds the set array and the per-set LRU bits.
- Gives a zero-latency taken/target prediction for the fetch PC.
- Carries that prediction through ID to EX, and presents to the EX-stage update logic the current set, tag, index and LRU for the resolving branch.
- Commits the updated set and LRU bit that the update logic sends back.

Parameters:
- NUM_SETS, 8, number of sets (index width = log2(NUM_SETS) = 3)
- TAG_W, 27, tag width (PC[31:5])

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- pc_if  in  32  fetch PC
- stall  in  1  hold the IF/ID and ID/EX prediction registers
- flush  in  1  clear the IF/ID and ID/EX prediction registers
- pc_ex  in  32  PC of the branch resolving in EX
- update_en  in  1  commit write_set and next_LRU_write this cycle
- write_set  in  128  updated set from the update logic
- next_LRU_write  in  1  new LRU bit for the pc_ex set
- predict_taken  out  1  combinational IF prediction
- predict_target  out  32  combinational IF target (0 when not taken)
- predict_taken_ex  out  1  prediction made for the instruction now in EX
- predict_target_ex  out  32  target predicted for the instruction now in EX
- update_set  out  128  set currently stored at the pc_ex index
- update_tag  out  27  pc_ex[31:5]
- update_index  out  3  pc_ex[4:2]
- LRU  out  8  LRU register, one bit per set

Behaviour:
- Set layout (128 bits): way1 = [127:64], way2 = [63:0].
- Way layout (64 bits):
  - [63] valid
  - [62:36] tag
  - [35:4] target
  - [3:2] 2-bit counter state
  - [1:0] zero
- Address split: index = pc[4:2], tag = pc[31:5]. pc[1:0] is ignored.
- Hit: way valid and way tag == pc_if tag.
- Predict taken: hit and state[1] == 1 (WEAK_TAKEN 10 or STRONG_TAKEN 11).
- predict_target = target of the hitting way when predicted taken, else 32'h0.
- Both ways hit (illegal): way1 wins.
- IF read bypass (write-first): when update_en and pc_ex index == pc_if index, the IF lookup uses write_set, not the stored set.
- update_set, update_tag, update_index: purely combinational from pc_ex and the stored array. No bypass, because the write is the same cycle.
- Write: on clk rising edge with update_en=1 and rst=0:
  - set[update_index] <= write_set
  - LRU[update_index] <= next_LRU_write
  - No other set or LRU bit changes.
- LRU is never modified by lookups.
- Prediction pipeline: two register stages, IF/ID then ID/EX, each holding {taken, target}.
  - With no stall or flush, predict_*_ex reflects the pc_if lookup from 2 cycles earlier.
  - flush=1: both stages load zero. Flush wins over stall.
  - stall=1 (no flush): both stages hold their values.
  - Array writes are unaffected by stall and flush.
- Reset (synchronous):
  - Whole array cleared to 0, so all ways are invalid.
  - LRU = 8'h00.
  - Pipeline registers = 0.
  - update_en is ignored while rst=1.
- Outputs after reset: predict_taken=0, predict_target=0, predict_taken_ex=0, predict_target_ex=0, LRU=0, update_set=0.
- rst asserted mid-operation overrides any update or stall in that cycle.
- Array implemented as registers (async read); no SRAM macro.

Decomposition:
- The defines header holds:
  - Counter encodings: STRONG_NOT_TAKEN 00, WEAK_NOT_TAKEN 01, WEAK_TAKEN 10, STRONG_TAKEN 11.
  - Way field bit positions (valid, tag, target, state).
  - BTB_SETS and BTB_TAG_W.
- One sub-module: btb_way_match. It takes a 64-bit way and a tag, and outputs hit, taken and target. It is instantiated twice, for way1 and way2.

Test Plan:
- After reset, pc_if=0x100 -> predict_taken=0, predict_target=0, LRU=0x00, update_set=0.
- Write then hit on way1:
  - Stimulus: update_en=1, pc_ex=0x1004, write_set way1 = {valid=1, tag=0x80, target=0x2000, state=10}.
  - Next cycle pc_if=0x1004 -> predict_taken=1, predict_target=0x2000.
  - pc_if=0x1024 (same index, different tag) -> predict_taken=0.
- Not-taken state: same entry with state=01 -> predict_taken=0, predict_target=0.
- Bypass: update_en=1 with pc_ex=pc_if=0x3008 in the same cycle, write_set way2 valid with state=11 and target=0x40 -> predict_taken=1 and predict_target=0x40 that cycle.
- Pipeline and stall/flush:
  - pc_if hit at cycle t -> predict_taken_ex=1 at t+2.
  - stall at t+1 -> the value appears at t+3.
  - flush at t+1 -> predict_taken_ex=0 at t+2.
- LRU and reset:
  - update_en with next_LRU_write=1, pc_ex index 5 -> LRU=0x20.
  - rst asserted together with update_en -> LRU=0x00 and the array stays clear.
